op_decoder: RTL and testbench
=============================

Name: op_decoder

Overview:
- Decodes one 21-bit TIS-100 node instruction word into the control fields that drive a single execution node's PC unit, ALU, ACC/BAK register file, input-select mux and output-port path.
- Sits between the node's instruction memory and its datapath.
- All outputs are registered, one cycle after `op_code` is presented.

Parameters:
- None. Field widths are fixed.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op_code  in  21  instruction word. [20:17]=opcode, [16:14]=src, [13:3]=const (signed), [2:0]=dst.
- src  out  3  registered copy of op_code[16:14].
- const  out  11  signed; registered copy of op_code[13:3]. Carries the immediate value or the jump target.
- dst  out  3  registered copy of op_code[2:0].
- pc_instr  out  4  PC operation.
- alu_instr  out  2  ALU operation.
- registers_instr  out  2  ACC/BAK operation.
- in_mux_sel  out  2  source-operand mux select.
- out_mux_sel  out  1  1 = drive the operand out to a port.
- illegal  out  1  1 = opcode 13..15 was decoded.

Behaviour:
- Opcode encoding: 0 NOP, 1 MOV, 2 SWP, 3 SAV, 4 ADD, 5 SUB, 6 NEG, 7 JMP, 8 JEZ, 9 JNZ, 10 JGZ, 11 JLZ, 12 JRO, 13-15 illegal.
- src encoding: 0 IMM (use const), 1 ACC, 2 NIL, 3 LEFT, 4 RIGHT, 5 UP, 6 DOWN, 7 ANY.
- dst encoding: 0 ACC, 1 NIL, 2 LEFT, 3 RIGHT, 4 UP, 5 DOWN, 6 ANY, 7 reserved (treated as NIL).
- Registering: every output is a flop loaded each cycle from combinational decode of op_code. Latency is exactly 1 cycle; there is no enable or stall.
- Reset: when rst=1 at a rising edge, all outputs go to 0 (src, const, dst, pc_instr, alu_instr, registers_instr, in_mux_sel, out_mux_sel, illegal). This all-zero state equals a NOP decode with in_mux_sel=0.
  - Reset has priority over op_code in the same cycle.
  - Normal decode resumes on the first edge with rst=0.
- src, const and dst are passed through unconditionally for every opcode, including illegal ones. const keeps its sign bit; no extension or saturation is applied.
- pc_instr: 0 = PC+1 (all non-jump opcodes and illegal opcodes), 1 JMP, 2 JEZ, 3 JNZ, 4 JGZ, 5 JLZ, 6 JRO. Codes 7-15 are never produced.
- alu_instr: 0 PASS (result = operand) by default.
  - 1 ADD for opcode 4; 2 SUB for opcode 5; 3 NEG for opcode 6.
  - MOV uses 0.
- registers_instr: 0 HOLD by default.
  - 1 WRITE_ACC for MOV with dst=0, and for ADD, SUB and NEG.
  - 2 SWP; 3 SAV.
- in_mux_sel, for MOV, ADD, SUB and JRO:
  - src=0 gives 0 (const).
  - src=1 gives 1 (ACC).
  - src=2 gives 2 (zero).
  - src=3..7 gives 3 (port read).
- in_mux_sel for all other opcodes: 2 (zero), so no port read is ever requested.
- out_mux_sel: 1 only for MOV with dst in 2..6; 0 otherwise, including MOV to ACC, NIL or reserved dst.
- Illegal opcodes (13-15):
  - Control outputs decode exactly as NOP: pc_instr=0, alu=0, regs=0, in_mux_sel=2, out_mux_sel=0.
  - illegal=1 for that one registered cycle.
- Back-to-back instructions: each cycle's output reflects only the previous cycle's op_code. No state is carried between instructions.

Test Plan:
- Reset: rst=1 with op_code=MOV LEFT,RIGHT → next edge all outputs 0. Release rst → the following edge shows pc=0, alu=0, regs=0, in_mux_sel=3, out_mux_sel=1, src=3, dst=3.
- ADD immediate: opcode=4, src=0, const=-5 (11'h7FB) → const=-5, alu=1, regs=1, in_mux_sel=0, out_mux_sel=0, pc=0.
- MOV ACC to ACC, then MOV ACC to NIL:
  - opcode=1, src=1, dst=0 → regs=1, in_mux_sel=1, out_mux_sel=0.
  - Next cycle dst=1 → regs=0, out_mux_sel=0.
- Jumps: JMP const=7 → pc=1, const=7. JLZ → pc=5. JRO src=4 → pc=6, in_mux_sel=3, alu=0, regs=0.
- SWP, SAV, NEG sequence on consecutive cycles:
  - SWP → regs=2, alu=0.
  - SAV → regs=3.
  - NEG → regs=1, alu=3, in_mux_sel=2.
  - Each appears exactly 1 cycle after its input.
- Illegal opcode 14 with src=5, const=999, dst=2 → illegal=1, pc=0, alu=0, regs=0, in_mux_sel=2, out_mux_sel=0, src=5, const=999, dst=2. The following NOP → illegal=0.

Source files
------------

// File: rtl/op_decoder.sv
// TIS-100 node instruction decoder: splits a 21-bit instruction word into registered
// PC/ALU/register-file/mux control fields, one cycle after the word is presented.
module op_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] op_code,
  output logic [2:0]  src,
  output logic [10:0] const_val,
  output logic [2:0]  dst,
  output logic [3:0]  pc_instr,
  output logic [1:0]  alu_instr,
  output logic [1:0]  registers_instr,
  output logic [1:0]  in_mux_sel,
  output logic        out_mux_sel,
  output logic        illegal
);

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,  OP_MOV = 4'd1,  OP_SWP = 4'd2,  OP_SAV = 4'd3,
    OP_ADD = 4'd4,  OP_SUB = 4'd5,  OP_NEG = 4'd6,  OP_JMP = 4'd7,
    OP_JEZ = 4'd8,  OP_JNZ = 4'd9,  OP_JGZ = 4'd10, OP_JLZ = 4'd11,
    OP_JRO = 4'd12
  } opcode_e;

  logic [3:0] opc;
  logic [2:0] src_f;
  logic [2:0] dst_f;

  logic [3:0] pc_d;
  logic [1:0] alu_d;
  logic [1:0] regs_d;
  logic [1:0] in_d;
  logic [1:0] src_sel;
  logic       out_d;
  logic       ill_d;

  assign opc   = op_code[20:17];
  assign src_f = op_code[16:14];
  assign dst_f = op_code[2:0];

  // Operand select for instructions that actually consume src: every port source
  // (LEFT..ANY) collapses onto the single port-read input.
  always_comb begin
    case (src_f)
      3'd0:    src_sel = 2'd0;
      3'd1:    src_sel = 2'd1;
      3'd2:    src_sel = 2'd2;
      default: src_sel = 2'd3;
    endcase
  end

  always_comb begin
    pc_d   = 4'd0;
    alu_d  = 2'd0;
    regs_d = 2'd0;
    in_d   = 2'd2;
    out_d  = 1'b0;
    ill_d  = 1'b0;
    case (opc)
      OP_NOP: ;
      OP_MOV: begin
        in_d   = src_sel;
        regs_d = (dst_f == 3'd0) ? 2'd1 : 2'd0;
        out_d  = (dst_f >= 3'd2) && (dst_f <= 3'd6);
      end
      OP_SWP: regs_d = 2'd2;
      OP_SAV: regs_d = 2'd3;
      OP_ADD: begin
        alu_d  = 2'd1;
        regs_d = 2'd1;
        in_d   = src_sel;
      end
      OP_SUB: begin
        alu_d  = 2'd2;
        regs_d = 2'd1;
        in_d   = src_sel;
      end
      OP_NEG: begin
        alu_d  = 2'd3;
        regs_d = 2'd1;
      end
      OP_JMP: pc_d = 4'd1;
      OP_JEZ: pc_d = 4'd2;
      OP_JNZ: pc_d = 4'd3;
      OP_JGZ: pc_d = 4'd4;
      OP_JLZ: pc_d = 4'd5;
      OP_JRO: begin
        pc_d = 4'd6;
        in_d = src_sel;
      end
      // 13..15 decode as NOP apart from the flag
      default: ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src             <= 3'd0;
      const_val       <= 11'd0;
      dst             <= 3'd0;
      pc_instr        <= 4'd0;
      alu_instr       <= 2'd0;
      registers_instr <= 2'd0;
      in_mux_sel      <= 2'd0;
      out_mux_sel     <= 1'b0;
      illegal         <= 1'b0;
    end else begin
      src             <= src_f;
      const_val       <= op_code[13:3];
      dst             <= dst_f;
      pc_instr        <= pc_d;
      alu_instr       <= alu_d;
      registers_instr <= regs_d;
      in_mux_sel      <= in_d;
      out_mux_sel     <= out_d;
      illegal         <= ill_d;
    end
  end

endmodule

// File: tb/tb_op_decoder.sv
// Bench for op_decoder: directed instruction words with hand-written expected decodes
// queued at issue and compared by an independent monitor one cycle later.
module tb_op_decoder;

  logic        clk;
  logic        rst;
  logic [20:0] op_code;
  logic [2:0]  src;
  logic [10:0] const_val;
  logic [2:0]  dst;
  logic [3:0]  pc_instr;
  logic [1:0]  alu_instr;
  logic [1:0]  registers_instr;
  logic [1:0]  in_mux_sel;
  logic        out_mux_sel;
  logic        illegal;

  // {src, const, dst, pc, alu, regs, in_sel, out_sel, illegal}
  localparam int W = 29;
  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           checks = 0;
  int           errors = 0;
  int           vec_id = 0;

  op_decoder dut (
    .clk             (clk),
    .rst             (rst),
    .op_code         (op_code),
    .src             (src),
    .const_val       (const_val),
    .dst             (dst),
    .pc_instr        (pc_instr),
    .alu_instr       (alu_instr),
    .registers_instr (registers_instr),
    .in_mux_sel      (in_mux_sel),
    .out_mux_sel     (out_mux_sel),
    .illegal         (illegal)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] mk(input logic [3:0] o, input logic [2:0] s,
                                     input logic [10:0] c, input logic [2:0] d);
    return {o, s, c, d};
  endfunction

  // driver: apply one word on the falling edge and queue its expected decode
  task automatic drive(input logic r, input logic [20:0] word,
                       input logic [2:0] e_src, input logic [10:0] e_c, input logic [2:0] e_dst,
                       input logic [3:0] e_pc, input logic [1:0] e_alu, input logic [1:0] e_regs,
                       input logic [1:0] e_in, input logic e_out, input logic e_ill);
    @(negedge clk);
    rst     = r;
    op_code = word;
    vec_id++;
    exp_q.push_back({e_src, e_c, e_dst, e_pc, e_alu, e_regs, e_in, e_out, e_ill});
    id_q.push_back(vec_id);
  endtask

  // scoreboard monitor
  logic [W-1:0] got;
  logic [W-1:0] exp_v;
  int           id;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      id    = id_q.pop_front();
      got   = {src, const_val, dst, pc_instr, alu_instr, registers_instr,
               in_mux_sel, out_mux_sel, illegal};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL vec%0d got src=%0d c=%h dst=%0d pc=%0d alu=%0d regs=%0d in=%0d out=%0d ill=%0d exp src=%0d c=%h dst=%0d pc=%0d alu=%0d regs=%0d in=%0d out=%0d ill=%0d",
                 id, got[28:26], got[25:15], got[14:12], got[11:8], got[7:6], got[5:4], got[3:2], got[1], got[0],
                 exp_v[28:26], exp_v[25:15], exp_v[14:12], exp_v[11:8], exp_v[7:6], exp_v[5:4], exp_v[3:2], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    int wait_cycles;
    rst     = 1'b1;
    op_code = 21'd0;

    //       rst  word                              src c        dst pc alu regs in out ill
    // reset wins over a MOV LEFT,RIGHT, then the same word decodes normally
    drive(1'b1, mk(4'd1,  3'd3, 11'd0,   3'd3), 3'd0, 11'd0,   3'd0, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    drive(1'b0, mk(4'd1,  3'd3, 11'd0,   3'd3), 3'd3, 11'd0,   3'd3, 4'd0, 2'd0, 2'd0, 2'd3, 1'b1, 1'b0);
    // ADD -5
    drive(1'b0, mk(4'd4,  3'd0, 11'h7FB, 3'd0), 3'd0, 11'h7FB, 3'd0, 4'd0, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0);
    // MOV ACC,ACC then MOV ACC,NIL
    drive(1'b0, mk(4'd1,  3'd1, 11'd0,   3'd0), 3'd1, 11'd0,   3'd0, 4'd0, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0);
    drive(1'b0, mk(4'd1,  3'd1, 11'd0,   3'd1), 3'd1, 11'd0,   3'd1, 4'd0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0);
    // jumps
    drive(1'b0, mk(4'd7,  3'd0, 11'd7,   3'd0), 3'd0, 11'd7,   3'd0, 4'd1, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0);
    drive(1'b0, mk(4'd11, 3'd0, 11'd3,   3'd0), 3'd0, 11'd3,   3'd0, 4'd5, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0);
    drive(1'b0, mk(4'd12, 3'd4, 11'd0,   3'd0), 3'd4, 11'd0,   3'd0, 4'd6, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0);
    drive(1'b0, mk(4'd8,  3'd0, 11'd12,  3'd0), 3'd0, 11'd12,  3'd0, 4'd2, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0);
    drive(1'b0, mk(4'd9,  3'd1, 11'd1,   3'd0), 3'd1, 11'd1,   3'd0, 4'd3, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0);
    drive(1'b0, mk(4'd10, 3'd0, 11'd2,   3'd0), 3'd0, 11'd2,   3'd0, 4'd4, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0);
    // SWP, SAV, NEG back to back
    drive(1'b0, mk(4'd2,  3'd0, 11'd0,   3'd0), 3'd0, 11'd0,   3'd0, 4'd0, 2'd0, 2'd2, 2'd2, 1'b0, 1'b0);
    drive(1'b0, mk(4'd3,  3'd0, 11'd0,   3'd0), 3'd0, 11'd0,   3'd0, 4'd0, 2'd0, 2'd3, 2'd2, 1'b0, 1'b0);
    drive(1'b0, mk(4'd6,  3'd1, 11'd0,   3'd0), 3'd1, 11'd0,   3'd0, 4'd0, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0);
    // illegal 14 then NOP
    drive(1'b0, mk(4'd14, 3'd5, 11'd999, 3'd2), 3'd5, 11'd999, 3'd2, 4'd0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b1);
    drive(1'b0, mk(4'd0,  3'd0, 11'd0,   3'd0), 3'd0, 11'd0,   3'd0, 4'd0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0);
    // SUB NIL with max positive const, dst ignored
    drive(1'b0, mk(4'd5,  3'd2, 11'h3FF, 3'd6), 3'd2, 11'h3FF, 3'd6, 4'd0, 2'd2, 2'd1, 2'd2, 1'b0, 1'b0);
    // MOV ANY to reserved dst with most negative const
    drive(1'b0, mk(4'd1,  3'd7, 11'h400, 3'd7), 3'd7, 11'h400, 3'd7, 4'd0, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0);
    // MOV imm to ANY port, MOV NIL to LEFT
    drive(1'b0, mk(4'd1,  3'd0, 11'd5,   3'd6), 3'd0, 11'd5,   3'd6, 4'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    drive(1'b0, mk(4'd1,  3'd2, 11'd0,   3'd2), 3'd2, 11'd0,   3'd2, 4'd0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0);
    // ADD from port source, NOP with port src (no port read requested)
    drive(1'b0, mk(4'd4,  3'd6, 11'd0,   3'd1), 3'd6, 11'd0,   3'd1, 4'd0, 2'd1, 2'd1, 2'd3, 1'b0, 1'b0);
    drive(1'b0, mk(4'd0,  3'd3, 11'd0,   3'd4), 3'd3, 11'd0,   3'd4, 4'd0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0);
    // illegal 15 and 13 with port src / MOV-style dst
    drive(1'b0, mk(4'd15, 3'd3, 11'd0,   3'd3), 3'd3, 11'd0,   3'd3, 4'd0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b1);
    drive(1'b0, mk(4'd13, 3'd0, 11'h7FF, 3'd0), 3'd0, 11'h7FF, 3'd0, 4'd0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b1);
    // mid-stream reset over ADD, then resume
    drive(1'b1, mk(4'd4,  3'd1, 11'd9,   3'd0), 3'd0, 11'd0,   3'd0, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    drive(1'b0, mk(4'd5,  3'd0, 11'd9,   3'd5), 3'd0, 11'd9,   3'd5, 4'd0, 2'd2, 2'd1, 2'd0, 1'b0, 1'b0);

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 20) begin
      @(posedge clk);
      #2;
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0 pending", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
